// File: rtl/line_window_buffer.sv
// Row-ring line buffer: rows stream in word by word, and windows of
// KERNEL_LENGTH vertically aligned words are read out one column per request.
module line_window_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int BURST_LENGTH  = 32,
    parameter int KERNEL_LENGTH = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wen,
    input  logic [DATA_WIDTH-1:0]                    din,
    input  logic                                     ren,
    input  logic                                     slide,
    input  logic                                     flush,
    output logic [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0] dout,
    output logic                                     valid,
    output logic                                     full_flag,
    output logic                                     empty_flag,
    output logic [$clog2(KERNEL_LENGTH+2)-1:0]       rows_cnt,
    output logic                                     err_ovf,
    output logic                                     err_udf
);

    localparam int ROWS = KERNEL_LENGTH + 1;
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(BURST_LENGTH);
    localparam int NW   = $clog2(ROWS + 1);

    typedef logic [RW-1:0] row_t;

    logic [DATA_WIDTH-1:0] r_mem [ROWS][BURST_LENGTH];

    row_t                                     r_wrow, r_orow;
    logic [CW-1:0]                            r_wcol, r_rcol;
    logic [NW-1:0]                            r_cnt;
    logic [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0] r_dout;
    logic                                     r_valid, r_ovf, r_udf;

    logic          w_wr, w_rd, w_wlast, w_rlast;
    logic [NW-1:0] w_rel, w_cnt_nxt;

    // Row pointers wrap modulo ROWS, which need not be a power of two.
    function automatic row_t f_row_add(input row_t a, input int unsigned n);
        int unsigned s;
        s = 32'(a) + n;
        if (s >= unsigned'(ROWS))
            s = s - unsigned'(ROWS);
        return row_t'(s);
    endfunction

    assign full_flag  = (r_cnt == NW'(ROWS));
    assign empty_flag = (r_cnt < NW'(KERNEL_LENGTH));

    assign w_wr    = wen & ~full_flag & ~flush;
    assign w_rd    = ren & ~empty_flag & ~flush;
    assign w_wlast = (r_wcol == CW'(BURST_LENGTH - 1));
    assign w_rlast = (r_rcol == CW'(BURST_LENGTH - 1));

    // Row completion and release land as one net change.
    assign w_rel     = (w_rd & w_rlast) ?
                       (slide ? NW'(1) : NW'(KERNEL_LENGTH)) : '0;
    assign w_cnt_nxt = r_cnt + NW'(w_wr & w_wlast) - w_rel;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wrow][r_wcol] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrow  <= '0;
            r_wcol  <= '0;
            r_orow  <= '0;
            r_rcol  <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (flush) begin
            r_wrow  <= '0;
            r_wcol  <= '0;
            r_orow  <= '0;
            r_rcol  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_valid <= w_rd;
            r_cnt   <= w_cnt_nxt;
            if (wen & full_flag)
                r_ovf <= 1'b1;
            if (ren & empty_flag)
                r_udf <= 1'b1;
            if (w_wr) begin
                r_wcol <= r_wcol + CW'(1);
                if (w_wlast)
                    r_wrow <= f_row_add(r_wrow, 32'd1);
            end
            if (w_rd) begin
                r_rcol <= r_rcol + CW'(1);
                for (int k = 0; k < KERNEL_LENGTH; k++)
                    r_dout[k] <= r_mem[f_row_add(r_orow, unsigned'(k))][r_rcol];
                if (w_rlast)
                    r_orow <= f_row_add(r_orow,
                              slide ? 32'd1 : unsigned'(KERNEL_LENGTH));
            end
        end
    end

    assign dout     = r_dout;
    assign valid    = r_valid;
    assign rows_cnt = r_cnt;
    assign err_ovf  = r_ovf;
    assign err_udf  = r_udf;

endmodule

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter BURST_LENGTH, default 32, words per row; power of two, >=2.
REQ-003 SHALL have parameter KERNEL_LENGTH, default 3, rows per output window, >=1; physical rows ROWS = KERNEL_LENGTH+1.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wen  input  1  write request for din.
REQ-007 SHALL have port din  input  DATA_WIDTH  write data.
REQ-008 SHALL have port ren  input  1  window read request.
REQ-009 SHALL have port slide  input  1  release mode: 1 releases one row per window row, 0 releases KERNEL_LENGTH rows.
REQ-010 SHALL have port flush  input  1  synchronous clear of all contents.
REQ-011 SHALL have port dout  output  KERNEL_LENGTH x DATA_WIDTH  window column; dout[0] is the oldest row.
REQ-012 SHALL have port valid  output  1  dout holds a new column this cycle.
REQ-013 SHALL have port full_flag, empty_flag  output  1 each  occupancy status.
REQ-014 SHALL have port rows_cnt  output  $clog2(ROWS+1)  count of completed, unreleased rows.
REQ-015 SHALL have port err_ovf, err_udf  output  1 each  sticky overflow and underflow errors.

Function
REQ-016 SHALL store words in ROWS x BURST_LENGTH memory; write row pointer wrow, write column wcol, oldest-row pointer orow, read column rcol, all wrapping modulo their range.
REQ-017 SHALL accept a write when wen=1 and full_flag=0: mem[wrow][wcol]<=din, wcol++; at wcol wrap, wrow++ and rows_cnt++.
REQ-018 SHALL set full_flag=1 exactly when rows_cnt==ROWS; SHALL drop wen while full_flag=1, set err_ovf, and leave memory and pointers unchanged.
REQ-019 SHALL set empty_flag=1 exactly when rows_cnt<KERNEL_LENGTH.
REQ-020 SHALL accept a read when ren=1 and empty_flag=0: dout[k]<=mem[(orow+k) mod ROWS][rcol] for k=0..KERNEL_LENGTH-1, rcol++.
REQ-021 SHALL assert valid for exactly one cycle, one cycle after each accepted read, with dout registered at the same edge; dout SHALL hold its value otherwise.
REQ-022 SHALL drop ren while empty_flag=1, keep valid=0, and set err_udf.
REQ-023 SHALL, at rcol wrap, use slide sampled on that read: slide=1 -> orow+=1, rows_cnt-=1; slide=0 -> orow+=KERNEL_LENGTH, rows_cnt-=KERNEL_LENGTH.
REQ-024 SHALL apply a same-cycle write row completion and read row release as one net update of rows_cnt.
REQ-025 SHALL evaluate full_flag and empty_flag from registered state only, so a row released this cycle becomes writable next cycle.
REQ-026 SHALL make flush=1 override wen and ren: pointers, rows_cnt, valid, err_ovf, and err_udf go to 0; memory and dout are not cleared.
REQ-027 SHALL keep err_ovf and err_udf set until reset or flush.

Reset
REQ-028 SHALL, with rst=0, asynchronously clear wrow, wcol, orow, rcol, rows_cnt, dout, valid, err_ovf, and err_udf to 0, giving full_flag=0 and empty_flag=1.
REQ-029 SHALL leave memory contents undefined after reset; no read may expose them before rewrite.
REQ-030 SHALL, on assertion of rst mid-burst, discard any partial row and accept a write on the first rising edge after release.

Verification (KERNEL_LENGTH=3, BURST_LENGTH=32)
REQ-031 Reset: pulse rst=0 -> dout=0, valid=0, rows_cnt=0, empty_flag=1, full_flag=0, err_*=0.
REQ-032 slide=0: write 1..96, then ren for 32 cycles -> empty_flag=0 after word 96; read c gives valid, dout[0]=c+1, dout[1]=c+33, dout[2]=c+65; afterwards rows_cnt=0, empty_flag=1.
REQ-033 slide=1: write 1..128 -> full_flag=1; write 129 dropped, err_ovf=1; 32 reads (dout[0]=1..32), then rows_cnt=3, full_flag=0; next read -> dout[0]=33, dout[1]=65, dout[2]=97.
REQ-034 Simultaneous: rows_cnt=3 with row 4 at wcol=31, slide=1; final read (rcol=31) and write of word 32 on the same edge -> rows_cnt stays 3, full_flag=0.
REQ-035 Underflow and flush: ren with rows_cnt=0 -> valid=0, err_udf=1; write 40 words, flush -> rows_cnt=0, err_udf=0; write 1..96 -> first read dout[0]=1.
REQ-036 Reset mid-operation: after writing 50 words, assert rst for 1 cycle -> all REQ-028 values; write 1..96, then read -> dout[0]=1.
